// File: rtl/zap_mem_inv_block_mp_if.sv
// ---------------------------------------------------------------------------
// zap_mem_inv_block_mp_if
//
// Purpose: bundles the request/response signals of the multi-port tag/valid
// store so the store and its user agree on widths in one place.
//
// Signals:
//   i_clken    - clock enable for write, per-entry invalidate, pipeline advance
//   i_wen      - write enable
//   i_waddr    - write address
//   i_wdata    - write data
//   i_inv      - global invalidate (not gated by i_clken)
//   i_inv_one  - single-entry invalidate
//   i_inv_addr - single-entry invalidate address
//   i_raddr    - packed read addresses, port p in slice p
//   o_rdata    - packed read data, port p in slice p
//   o_rdav     - read valid per port
//   o_vcount   - number of currently valid entries
//
// Modports: master drives the requests, slave is the store itself.
// ---------------------------------------------------------------------------
interface zap_mem_inv_block_mp_if #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  i_clken;
    logic                  i_wen;
    logic [AW-1:0]         i_waddr;
    logic [WIDTH-1:0]      i_wdata;
    logic                  i_inv;
    logic                  i_inv_one;
    logic [AW-1:0]         i_inv_addr;
    logic [NUM_RD*AW-1:0]  i_raddr;
    logic [NUM_RD*WIDTH-1:0] o_rdata;
    logic [NUM_RD-1:0]     o_rdav;
    logic [CW-1:0]         o_vcount;

    modport master (
        output i_clken, i_wen, i_waddr, i_wdata, i_inv, i_inv_one,
               i_inv_addr, i_raddr,
        input  o_rdata, o_rdav, o_vcount
    );

    modport slave (
        input  i_clken, i_wen, i_waddr, i_wdata, i_inv, i_inv_one,
               i_inv_addr, i_raddr,
        output o_rdata, o_rdav, o_vcount
    );
endinterface

// File: rtl/zap_mem_inv_block_mp.sv
// ---------------------------------------------------------------------------
// zap_mem_inv_block_mp
//
// Purpose: tag/valid store with NUM_RD independent read ports, a single-cycle
// global invalidate, a per-entry invalidate, RD_LAT-cycle read pipelines kept
// coherent with in-flight updates, and a registered valid-entry counter.
//
// Ports:
//   i_clk    - clock
//   i_reset  - synchronous active-high reset
//   bus      - zap_mem_inv_block_mp_if.slave carrying write, invalidate,
//              read address, read data/valid and valid-count signals
// ---------------------------------------------------------------------------
module zap_mem_inv_block_mp #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int NUM_RD = 2,
    parameter int RD_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    zap_mem_inv_block_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry storage: data is never reset, valid bits are.
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_vcount;

    // Read pipelines, one row per port, stage RD_LAT-1 drives the outputs.
    logic [AW-1:0]     r_pipeAddr  [NUM_RD][RD_LAT];
    logic [WIDTH-1:0]  r_pipeData  [NUM_RD][RD_LAT];
    logic [RD_LAT-1:0] r_pipeValid [NUM_RD];

    // Next-state of every pipeline stage with this cycle's updates folded in.
    logic [AW-1:0]     w_nextAddr  [NUM_RD][RD_LAT];
    logic [WIDTH-1:0]  w_nextData  [NUM_RD][RD_LAT];
    logic [RD_LAT-1:0] w_nextValid [NUM_RD];

    logic w_wrEn;
    logic w_invOneEn;
    logic w_sameAddr;
    logic w_wrInc;
    logic w_invDec;

    // Qualified update strobes. An invalidate-one on the same address as a
    // write cancels the valid bit the write would set, so such a write never
    // counts as a new valid entry; the invalidate only counts when the entry
    // was valid before the edge.
    always_comb begin
        w_wrEn     = bus.i_clken & bus.i_wen;
        w_invOneEn = bus.i_clken & bus.i_inv_one;
        w_sameAddr = (bus.i_waddr == bus.i_inv_addr);
        w_wrInc    = w_wrEn & ~r_valid[bus.i_waddr] & ~(w_invOneEn & w_sameAddr);
        w_invDec   = w_invOneEn & r_valid[bus.i_inv_addr];
    end

    // Pipeline next-state. Stage 0 reads the array and forwards this cycle's
    // write/invalidate so a write in the same cycle as the read is visible.
    // Later stages take the previous stage and apply the same rules, so a
    // read always returns the entry as it stands after the last enabled cycle.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_nextValid[p] = '0;
            for (int s = 0; s < RD_LAT; s++) begin
                w_nextAddr[p][s] = '0;
                w_nextData[p][s] = '0;
            end

            w_nextAddr[p][0]  = bus.i_raddr[p*AW +: AW];
            w_nextData[p][0]  = r_data[w_nextAddr[p][0]];
            w_nextValid[p][0] = r_valid[w_nextAddr[p][0]];
            if (w_wrEn && (bus.i_waddr == w_nextAddr[p][0])) begin
                w_nextData[p][0]  = bus.i_wdata;
                w_nextValid[p][0] = 1'b1;
            end
            if (w_invOneEn && (bus.i_inv_addr == w_nextAddr[p][0])) begin
                w_nextValid[p][0] = 1'b0;
            end

            for (int s = 1; s < RD_LAT; s++) begin
                w_nextAddr[p][s]  = r_pipeAddr[p][s-1];
                w_nextData[p][s]  = r_pipeData[p][s-1];
                w_nextValid[p][s] = r_pipeValid[p][s-1];
                if (w_wrEn && (bus.i_waddr == w_nextAddr[p][s])) begin
                    w_nextData[p][s]  = bus.i_wdata;
                    w_nextValid[p][s] = 1'b1;
                end
                if (w_invOneEn && (bus.i_inv_addr == w_nextAddr[p][s])) begin
                    w_nextValid[p][s] = 1'b0;
                end
            end
        end
    end

    // Array data write. Kept apart from the reset chain so the storage has no
    // reset and can map onto plain memory; reset and global invalidate still
    // block the write because they discard everything else that cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !bus.i_inv && w_wrEn) begin
            r_data[bus.i_waddr] <= bus.i_wdata;
        end
    end

    // Valid bits, counter and read pipelines. Reset clears everything except
    // array data; global invalidate only drops valid bits and the count while
    // addresses and data hold, so o_rdata keeps its last value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= '0;
            r_vcount <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                r_pipeValid[p] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    r_pipeAddr[p][s] <= '0;
                    r_pipeData[p][s] <= '0;
                end
            end
        end else if (bus.i_inv) begin
            r_valid  <= '0;
            r_vcount <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                r_pipeValid[p] <= '0;
            end
        end else if (bus.i_clken) begin
            // The invalidate is applied second so it wins on a shared address.
            if (w_wrEn) begin
                r_valid[bus.i_waddr] <= 1'b1;
            end
            if (w_invOneEn) begin
                r_valid[bus.i_inv_addr] <= 1'b0;
            end
            r_vcount <= r_vcount + {{(CW-1){1'b0}}, w_wrInc}
                                 - {{(CW-1){1'b0}}, w_invDec};
            for (int p = 0; p < NUM_RD; p++) begin
                r_pipeValid[p] <= w_nextValid[p];
                for (int s = 0; s < RD_LAT; s++) begin
                    r_pipeAddr[p][s] <= w_nextAddr[p][s];
                    r_pipeData[p][s] <= w_nextData[p][s];
                end
            end
        end
    end

    // Outputs come straight from the last pipeline stage and the counter.
    always_comb begin
        bus.o_rdata  = '0;
        bus.o_rdav   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.o_rdata[p*WIDTH +: WIDTH] = r_pipeData[p][RD_LAT-1];
            bus.o_rdav[p]                 = r_pipeValid[p][RD_LAT-1];
        end
        bus.o_vcount = r_vcount;
    end
endmodule

// File: tb/tb_zap_mem_inv_block_mp.sv
// ---------------------------------------------------------------------------
// tb_zap_mem_inv_block_mp
//
// Purpose: directed self-checking bench for zap_mem_inv_block_mp with the
// default configuration (DEPTH=32, WIDTH=32, NUM_RD=2, RD_LAT=2).
// Inputs change 1ns after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_zap_mem_inv_block_mp;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    zap_mem_inv_block_mp_if #(.DEPTH(32), .WIDTH(32), .NUM_RD(2)) bus ();

    zap_mem_inv_block_mp #(
        .DEPTH(32), .WIDTH(32), .NUM_RD(2), .RD_LAT(2)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of inputs, then waits for the edge plus 1ns so the
    // caller sees the post-edge register state.
    task automatic applyStimulus(
        input logic        rst,
        input logic        clken,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic        inv,
        input logic        invOne,
        input logic [4:0]  invAddr,
        input logic [4:0]  ra0,
        input logic [4:0]  ra1
    );
        reset          = rst;
        bus.i_clken    = clken;
        bus.i_wen      = wen;
        bus.i_waddr    = waddr;
        bus.i_wdata    = wdata;
        bus.i_inv      = inv;
        bus.i_inv_one  = invOne;
        bus.i_inv_addr = invAddr;
        bus.i_raddr    = {ra1, ra0};
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(
        input string       tag,
        input logic [63:0] observed,
        input logic [63:0] expected
    );
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, basic read, same-cycle forwarding,
    // global invalidate, write+invalidate collisions, clock-enable freeze and
    // reset in the middle of a read.
    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset state
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_rdav",   64'(bus.o_rdav),   64'h0);
        checkOutput("reset_rdata",  64'(bus.o_rdata),  64'h0);
        checkOutput("reset_vcount", 64'(bus.o_vcount), 64'h0);

        // Write 5 then read it on port 0 with two cycles of latency
        applyStimulus(0, 1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        checkOutput("t1_vcount", 64'(bus.o_vcount), 64'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("t1_not_yet", 64'(bus.o_rdav[0]), 64'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rdata0", 64'(bus.o_rdata[31:0]), 64'hDEAD_BEEF);
        checkOutput("t1_rdav0",  64'(bus.o_rdav[0]),     64'h1);

        // Write to 3 lands while the read of 3 is in flight
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 3, 7);
        applyStimulus(0, 1, 1, 3, 32'h11, 0, 0, 0, 0, 0);
        checkOutput("t2_rdata0", 64'(bus.o_rdata[31:0]), 64'h11);
        checkOutput("t2_rdav0",  64'(bus.o_rdav[0]),     64'h1);
        checkOutput("t2_rdav1",  64'(bus.o_rdav[1]),     64'h0);
        checkOutput("t2_vcount", 64'(bus.o_vcount),      64'd2);

        // Fill all entries, counter saturates at DEPTH
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1, 1, i[4:0], 32'h100 + 32'(i), 0, 0, 0, 0, 0);
        end
        checkOutput("t3_full", 64'(bus.o_vcount), 64'd32);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 10, 20);
        checkOutput("t3_pre_inv_rdav0", 64'(bus.o_rdav[0]), 64'h1);
        // Global invalidate with clock enable low
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 10, 20);
        checkOutput("t3_inv_vcount", 64'(bus.o_vcount),      64'd0);
        checkOutput("t3_inv_rdav",   64'(bus.o_rdav),        64'h0);
        checkOutput("t3_inv_rdata0", 64'(bus.o_rdata[31:0]), 64'h100);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 10, 31);
        checkOutput("t3_flushed_rdav", 64'(bus.o_rdav), 64'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_after_rdav",  64'(bus.o_rdav),        64'h0);
        checkOutput("t3_after_data",  64'(bus.o_rdata[31:0]), 64'h10A);

        // Write and invalidate of the same valid entry
        applyStimulus(0, 1, 1, 9, 32'h99, 0, 0, 0, 0, 0);
        checkOutput("t4_vcount_w9", 64'(bus.o_vcount), 64'd1);
        applyStimulus(0, 1, 1, 9, 32'h77, 0, 1, 9, 9, 0);
        checkOutput("t4_vcount_dec", 64'(bus.o_vcount), 64'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_rdav9",  64'(bus.o_rdav[0]),     64'h0);
        checkOutput("t4_rdata9", 64'(bus.o_rdata[31:0]), 64'h77);
        // Same again with the entry already invalid
        applyStimulus(0, 1, 1, 1, 32'h1, 0, 0, 0, 0, 0);
        checkOutput("t4_vcount_w1", 64'(bus.o_vcount), 64'd1);
        applyStimulus(0, 1, 1, 9, 32'h55, 0, 1, 9, 0, 0);
        checkOutput("t4_vcount_same", 64'(bus.o_vcount), 64'd1);
        // Write and invalidate on different addresses
        applyStimulus(0, 1, 1, 2, 32'h22, 0, 1, 1, 0, 0);
        checkOutput("t4_vcount_diff", 64'(bus.o_vcount), 64'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_rdav_inv1", 64'(bus.o_rdav[0]),      64'h0);
        checkOutput("t4_rdav_w2",   64'(bus.o_rdav[1]),      64'h1);
        checkOutput("t4_rdata_w2",  64'(bus.o_rdata[63:32]), 64'h22);

        // Clock enable low for three cycles with a read of 2 in flight
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2, 0);
        checkOutput("t5_pre_rdav0",  64'(bus.o_rdav[0]),     64'h0);
        checkOutput("t5_pre_rdata0", 64'(bus.o_rdata[31:0]), 64'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 2, 32'hAA, 0, 0, 0, 9, 9);
            checkOutput("t5_frz_vcount", 64'(bus.o_vcount),      64'd1);
            checkOutput("t5_frz_rdav0",  64'(bus.o_rdav[0]),     64'h0);
            checkOutput("t5_frz_rdata0", 64'(bus.o_rdata[31:0]), 64'h100);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_rel_rdata0", 64'(bus.o_rdata[31:0]), 64'h22);
        checkOutput("t5_rel_rdav0",  64'(bus.o_rdav[0]),     64'h1);
        checkOutput("t5_rel_vcount", 64'(bus.o_vcount),      64'd1);

        // Reset while a read is one stage from the output
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2, 2);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_rst_rdav",   64'(bus.o_rdav),   64'h0);
        checkOutput("t6_rst_vcount", 64'(bus.o_vcount), 64'd0);
        checkOutput("t6_rst_rdata",  64'(bus.o_rdata),  64'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_post_rdav",  64'(bus.o_rdav),   64'h0);
        checkOutput("t6_post_rdata", 64'(bus.o_rdata),  {32'h22, 32'h22});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/zap_mem_inv_block_mp.md
Name: zap_mem_inv_block_mp

Overview:
- Multi-read-port tag/valid store with single-cycle global invalidate, per-entry invalidate, configurable read latency and a live valid-entry counter.
- Read pipelines are kept coherent with in-flight writes and invalidates, so returned data and valid always reflect the latest array state.
- Used by TLBs and cache tag arrays that need parallel lookups, such as separate I-side and D-side walks, and selective shootdown.

Parameters:
- DEPTH, 32, number of entries; power of 2, at least 2.
- WIDTH, 32, data width per entry, excluding the valid bit.
- NUM_RD, 2, number of independent read ports, 1 to 4.
- RD_LAT, 2, read latency in enabled cycles, 1 to 3.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_clken  in  1  clock enable for the write, per-entry invalidate and pipeline advance.
- i_wen  in  1  write enable.
- i_waddr  in  $clog2(DEPTH)  write address.
- i_wdata  in  WIDTH  write data.
- i_inv  in  1  global invalidate; not gated by i_clken.
- i_inv_one  in  1  single-entry invalidate.
- i_inv_addr  in  $clog2(DEPTH)  address for the single-entry invalidate.
- i_raddr  in  NUM_RD*$clog2(DEPTH)  read addresses; port p occupies slice p.
- o_rdata  out  NUM_RD*WIDTH  read data per port.
- o_rdav  out  NUM_RD  read valid per port.
- o_vcount  out  $clog2(DEPTH+1)  number of currently valid entries.

Behaviour:
- Priority: i_reset > i_inv > i_clken-gated operations. When i_clken=0 and i_inv=0, all state holds.
- Reset clears:
  - all entry valid bits,
  - all pipeline valid bits and pipeline addresses,
  - o_rdav to 0, o_rdata to 0, o_vcount to 0.
  - Array data is not reset.
- Global invalidate (i_inv): in one cycle it clears
  - all entry valid bits,
  - every pipeline stage valid, including o_rdav,
  - o_vcount to 0.
  - Array data and o_rdata hold. Any write or inv_one in the same cycle is discarded.
- Write (i_wen & i_clken): the entry takes i_wdata and its valid bit is set.
- Per-entry invalidate (i_inv_one & i_clken): clears the valid bit of i_inv_addr; data holds.
- Write and per-entry invalidate in the same cycle:
  - Same address: the invalidate wins for the valid bit and the data is still written. The entry ends invalid.
  - Different addresses: both apply.
- Read latency: an address presented on port p in enabled cycle t appears on o_rdata/o_rdav slice p after RD_LAT enabled cycles. A new read is accepted every enabled cycle on each port.
- Coherency: each pipeline stage holds {addr, data, valid}. In every enabled cycle each stage compares its address with i_waddr and i_inv_addr and applies the same update rules as the array.
  - The output therefore equals the entry state after all updates up to and including the enabled cycle before the output appears.
  - A write in the same cycle as the read is visible.
- Ports: read ports are fully independent. Identical addresses on several ports return identical results.
- o_vcount is registered and updates on the same edge as the array:
  - +1 for a write to an invalid entry that is not cancelled by an inv_one to the same address.
  - -1 for an inv_one to a valid entry.
  - A write and an inv_one to the same address when the entry was valid gives -1; when it was invalid, 0.
  - Writes to different addresses combine arithmetically. Net range is -1 to +1 per cycle.
  - Never exceeds DEPTH and never goes below 0.
- Reset mid-read: in-flight reads are dropped, o_rdav=0 from the next cycle, and the pipeline accepts reads immediately after.

Test Plan:
1. Reset, write addr 5 = 0xDEAD_BEEF, then read port0 addr 5 (RD_LAT=2) -> o_rdata[0]=0xDEADBEEF, o_rdav[0]=1 two cycles later; o_vcount=1.
2. Read port0 addr 3 and port1 addr 7 in cycle t, with a write of 3 = 0x11 in cycle t+1 -> at t+2 port0 gives 0x11 valid=1; port1 gives valid=0 (7 was never written).
3. Fill all 32 entries, then assert i_inv in a cycle where i_clken=0 -> o_vcount=0 next cycle, in-flight o_rdav=0, and later reads of any address return valid=0.
4. Write addr 9 and inv_one addr 9 in the same cycle, with 9 previously valid -> read of 9 gives valid=0 and o_vcount decrements by 1. Repeat with 9 invalid -> o_vcount unchanged.
5. Hold i_clken=0 for 3 cycles with reads in flight and i_wen=1 -> outputs, array and o_vcount frozen. On release, the result appears after the remaining stages.
6. Assert reset while a read is one stage from the output -> o_rdav=0 and o_vcount=0 on the next cycle. A read issued immediately after reset deasserts returns valid=0 after RD_LAT cycles.
